// File: rtl/periph_bus_arbiter.sv
// Two-master, one-slave peripheral bus arbiter: round-robin grant, one
// transaction per grant, watchdog-forced error termination of hung transfers.
module periph_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_ce_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_ce_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,
  output logic        s_ce_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [31:0] s_data_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_data_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        gnt_act;
  logic        gnt_m1;
  logic        timeout;
  logic        done;
  logic [31:0] rsp_data;

  assign gnt_act  = (state_q == GRANT0) || (state_q == GRANT1);
  assign gnt_m1   = (state_q == GRANT1);
  // A slave ack on the final watchdog cycle counts as a normal completion.
  assign timeout  = gnt_act && !s_ack_i && (tcnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign done     = gnt_act && (s_ack_i || timeout);
  assign rsp_data = timeout ? ERR_DATA : s_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        // On a tie the master not served last wins.
        if (m0_ce_i && m1_ce_i) state_d = last_q ? GRANT0 : GRANT1;
        else if (m0_ce_i)       state_d = GRANT0;
        else if (m1_ce_i)       state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (done) begin
          state_d = IDLE;
          last_d  = gnt_m1;
          tcnt_d  = '0;
        end else begin
          tcnt_d  = tcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ce_o    = 1'b0;
    s_sel_o   = '0;
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_data_o  = '0;
    grant_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_data_o = '0;
    if (gnt_act) begin
      s_ce_o   = !timeout;
      s_sel_o  = gnt_m1 ? m1_sel_i  : m0_sel_i;
      s_addr_o = gnt_m1 ? m1_addr_i : m0_addr_i;
      s_we_o   = gnt_m1 ? m1_we_i   : m0_we_i;
      s_data_o = gnt_m1 ? m1_data_i : m0_data_i;
      grant_o  = gnt_m1 ? 2'b10 : 2'b01;
    end
    if (done && !gnt_m1) begin
      m0_ack_o  = 1'b1;
      m0_err_o  = timeout;
      m0_data_o = rsp_data;
    end
    if (done && gnt_m1) begin
      m1_ack_o  = 1'b1;
      m1_err_o  = timeout;
      m1_data_o = rsp_data;
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: write/read, alternation, timeout,
// ack-on-timeout-cycle and asynchronous reset during a grant.
module tb_periph_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_ce_i, m0_we_i, m1_ce_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        s_ce_o, s_we_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [1:0]  grant_o;

  int checks   = 0;
  int failures = 0;

  periph_bus_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_ce_i(m0_ce_i), .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i),
    .m0_we_i(m0_we_i), .m0_data_i(m0_data_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_data_o(m0_data_o),
    .m1_ce_i(m1_ce_i), .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i),
    .m1_we_i(m1_we_i), .m1_data_i(m1_data_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_data_o(m1_data_o),
    .s_ce_o(s_ce_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o),
    .s_we_o(s_we_o), .s_data_o(s_data_o),
    .s_ack_i(s_ack_i), .s_data_i(s_data_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_all();
    m0_ce_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_addr_i = 0; m0_data_i = 0;
    m1_ce_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_addr_i = 0; m1_data_i = 0;
    s_ack_i = 0; s_data_i = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_sce"},   s_ce_o, 0);
    chk({tag, "_m0ack"}, m0_ack_o, 0);
    chk({tag, "_m1ack"}, m1_ack_o, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    idle_all();
    #1;
    chk_quiet("rst");
    chk("rst_saddr", s_addr_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_i = 1'b0;

    // Write from m0, slave acks in the same cycle.
    cyc();
    m0_ce_i = 1; m0_we_i = 1; m0_sel_i = 4'hF; m0_addr_i = 32'h4; m0_data_i = 32'hA5A5_0001;
    #1 chk_quiet("wr_c0");
    cyc();
    s_ack_i = 1;
    #1;
    chk("wr_sce",   s_ce_o, 1);
    chk("wr_swe",   s_we_o, 1);
    chk("wr_ssel",  s_sel_o, 4'hF);
    chk("wr_saddr", s_addr_o, 32'h4);
    chk("wr_sdata", s_data_o, 32'hA5A5_0001);
    chk("wr_grant", grant_o, 2'b01);
    chk("wr_m0ack", m0_ack_o, 1);
    chk("wr_m0err", m0_err_o, 0);
    chk("wr_m1ack", m1_ack_o, 0);
    cyc();
    idle_all();
    #1 chk_quiet("wr_c2");

    // Read from m1, slave data one cycle after ce.
    cyc();
    m1_ce_i = 1; m1_we_i = 0; m1_sel_i = 4'h3; m1_addr_i = 32'h0;
    cyc();
    #1;
    chk("rd_grant", grant_o, 2'b10);
    chk("rd_sce",   s_ce_o, 1);
    chk("rd_ssel",  s_sel_o, 4'h3);
    chk("rd_m1ack_early", m1_ack_o, 0);
    cyc();
    s_ack_i = 1; s_data_i = 32'h1234_5678;
    #1;
    chk("rd_m1ack",  m1_ack_o, 1);
    chk("rd_m1data", m1_data_o, 32'h1234_5678);
    chk("rd_m1err",  m1_err_o, 0);
    chk("rd_m0ack",  m0_ack_o, 0);
    chk("rd_m0data", m0_data_o, 0);
    cyc();
    idle_all();
    #1 chk_quiet("rd_c3");

    // Continuous dual requests with slave ack tied high: grants alternate
    // 0,1,0,1 with one IDLE cycle between, and IDLE ignores s_ack_i.
    cyc();
    m0_ce_i = 1; m0_we_i = 1; m0_addr_i = 32'h10;
    m1_ce_i = 1; m1_we_i = 1; m1_addr_i = 32'h20;
    s_ack_i = 1; s_data_i = 32'h5555_AAAA;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        cyc();
        #1;
      end
      if (i % 2 == 0) begin
        chk($sformatf("rr%0d_grant", i), grant_o, 2'b00);
        chk($sformatf("rr%0d_m0ack", i), m0_ack_o, 0);
        chk($sformatf("rr%0d_m1ack", i), m1_ack_o, 0);
      end else begin
        chk($sformatf("rr%0d_grant", i), grant_o, ((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("rr%0d_m0ack", i), m0_ack_o, ((i / 2) % 2 == 0) ? 1 : 0);
        chk($sformatf("rr%0d_m1ack", i), m1_ack_o, ((i / 2) % 2 == 0) ? 0 : 1);
        chk($sformatf("rr%0d_saddr", i), s_addr_o, ((i / 2) % 2 == 0) ? 32'h10 : 32'h20);
      end
    end
    cyc();
    idle_all();
    #1 chk_quiet("rr_end");

    // m0 read times out; pending m1 is granted next.
    cyc();
    m0_ce_i = 1; m0_we_i = 0; m0_addr_i = 32'h30;
    m1_ce_i = 1; m1_we_i = 1; m1_addr_i = 32'h40;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      #1;
      chk($sformatf("to%0d_grant", k), grant_o, 2'b01);
      chk($sformatf("to%0d_m0ack", k), m0_ack_o, 0);
    end
    cyc();
    #1;
    chk("to16_sce",    s_ce_o, 0);
    chk("to16_grant",  grant_o, 2'b01);
    chk("to16_m0ack",  m0_ack_o, 1);
    chk("to16_m0err",  m0_err_o, 1);
    chk("to16_m0data", m0_data_o, 32'hDEAD_BEEF);
    chk("to16_m1ack",  m1_ack_o, 0);
    cyc();
    m0_ce_i = 0;
    #1 chk_quiet("to17");
    cyc();
    s_ack_i = 1;
    #1;
    chk("to18_grant", grant_o, 2'b10);
    chk("to18_m1ack", m1_ack_o, 1);
    chk("to18_m1err", m1_err_o, 0);
    cyc();
    idle_all();

    // Slave ack exactly on the watchdog cycle: normal completion.
    cyc();
    m0_ce_i = 1; m0_we_i = 0; m0_addr_i = 32'h50;
    for (int k = 1; k <= 15; k++) cyc();
    cyc();
    s_ack_i = 1; s_data_i = 32'hCAFE_0001;
    #1;
    chk("tack_sce",    s_ce_o, 1);
    chk("tack_m0ack",  m0_ack_o, 1);
    chk("tack_m0err",  m0_err_o, 0);
    chk("tack_m0data", m0_data_o, 32'hCAFE_0001);
    cyc();
    idle_all();

    // Reset in the middle of an m1 read; afterwards m0 wins the first tie.
    cyc();
    m1_ce_i = 1; m1_we_i = 0; m1_addr_i = 32'h60;
    cyc();
    #1 chk("rg_grant", grant_o, 2'b10);
    cyc();
    rst_i = 1; m0_ce_i = 1; s_ack_i = 1; s_data_i = 32'h7777_7777;
    #1;
    chk_quiet("rg_rst");
    chk("rg_saddr",  s_addr_o, 0);
    chk("rg_m1data", m1_data_o, 0);
    #3 rst_i = 0;
    s_ack_i = 0;
    cyc();
    #1;
    chk("rg_tie_grant", grant_o, 2'b01);
    chk("rg_tie_saddr", s_addr_o, 32'h0);
    cyc();
    idle_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
